// File: rtl/odd_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : odd_pipe_pkg
// Brief    : Shared types, latencies and helpers for the odd-pipe issue path.
// Revision : 1.0 - initial release
// ============================================================================
package odd_pipe_pkg;

  typedef enum logic [1:0] {
    UNIT_PERM  = 2'd0,
    UNIT_LS    = 2'd1,
    UNIT_BR    = 2'd2,
    UNIT_UNDEF = 2'd3
  } unit_e;

  localparam int LAT_BR   = 1;
  localparam int LAT_PERM = 4;
  localparam int LAT_LS   = 6;
  localparam int DEPTH    = 7;
  localparam int LAT_W    = 3;

  typedef struct packed {
    logic       valid;
    logic [0:6] addr;
  } resv_entry_t;

  // Undefined unit code behaves as Permute.
  function automatic logic [LAT_W-1:0] unit_lat(input unit_e u);
    case (u)
      UNIT_LS: unit_lat = LAT_W'(LAT_LS);
      UNIT_BR: unit_lat = LAT_W'(LAT_BR);
      default: unit_lat = LAT_W'(LAT_PERM);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/odd_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : odd_wb_scoreboard
// Brief    : Reservation shift register mirroring OddPipe fw stages 1..DEPTH;
//            flags writeback-slot, RAW and WAW hazards for the candidate instr.
// Revision : 1.0 - initial release
// ============================================================================
module odd_wb_scoreboard
  import odd_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_lat,
  input  logic             i_reg_write,
  input  logic [6:0]       i_rt_addr,
  input  logic [6:0]       i_ra_addr,
  input  logic [6:0]       i_rb_addr,
  input  logic [6:0]       i_rc_addr,
  input  logic             i_ra_used,
  input  logic             i_rb_used,
  input  logic             i_rc_used,
  output logic             o_struct_hz,
  output logic             o_raw_hz,
  output logic             o_waw_hz,
  output logic             o_busy
);

  resv_entry_t r_resv [1:DEPTH];

  logic [DEPTH:1] w_valid;
  logic [DEPTH:1] w_raw_hit;
  logic [DEPTH:1] w_waw_hit;
  logic           w_struct;

  // The load overrides the shifted-in value; the structural check keeps it empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 1; s <= DEPTH; s++) r_resv[s] <= '0;
    end else begin
      r_resv[1] <= '0;
      for (int s = 2; s <= DEPTH; s++) r_resv[s] <= r_resv[s-1];
      for (int s = 1; s <= DEPTH; s++) begin
        if (i_load && (i_lat == LAT_W'(s))) r_resv[s] <= {1'b1, i_rt_addr};
      end
    end
  end

  generate
    for (genvar s = 1; s <= DEPTH; s++) begin : g_match
      assign w_valid[s]   = r_resv[s].valid;
      assign w_raw_hit[s] = r_resv[s].valid &&
                            ((i_ra_used && (i_ra_addr == r_resv[s].addr)) ||
                             (i_rb_used && (i_rb_addr == r_resv[s].addr)) ||
                             (i_rc_used && (i_rc_addr == r_resv[s].addr)));
      assign w_waw_hit[s] = r_resv[s].valid && i_reg_write &&
                            (i_rt_addr == r_resv[s].addr);
    end
  endgenerate

  // Slot L is taken next cycle if whatever sits in L-1 now will shift into it.
  always_comb begin
    w_struct = 1'b0;
    for (int s = 1; s < DEPTH; s++) begin
      if (i_reg_write && (i_lat == LAT_W'(s + 1)) && r_resv[s].valid) w_struct = 1'b1;
    end
  end

  assign o_struct_hz = w_struct;
  assign o_raw_hz    = |w_raw_hit;
  assign o_waw_hz    = |w_waw_hit;
  assign o_busy      = |w_valid;

endmodule
`default_nettype wire

// File: rtl/odd_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : odd_issue_ctrl
// Brief    : Odd-pipe issue controller: valid/ready handshake, unit remap,
//            hazard stall and saturating stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module odd_issue_ctrl
  import odd_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       unit,
  input  logic [6:0]       rt_addr,
  input  logic             reg_write,
  input  logic [6:0]       ra_addr,
  input  logic [6:0]       rb_addr,
  input  logic [6:0]       rc_addr,
  input  logic             ra_used,
  input  logic             rb_used,
  input  logic             rc_used,
  input  logic             ext_stall,
  output logic             issue_valid,
  output logic [1:0]       issue_unit,
  output logic             busy,
  output logic [CNT_W-1:0] struct_stall_cnt,
  output logic [CNT_W-1:0] raw_stall_cnt
);

  unit_e            w_unit;
  logic [LAT_W-1:0] w_lat;
  logic             w_struct_hz;
  logic             w_raw_hz;
  logic             w_waw_hz;
  logic             w_issue;
  logic [CNT_W-1:0] r_struct_cnt;
  logic [CNT_W-1:0] r_raw_cnt;

  assign w_unit = unit_e'(unit);
  assign w_lat  = unit_lat(w_unit);

  odd_wb_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_issue && reg_write),
    .i_lat       (w_lat),
    .i_reg_write (reg_write),
    .i_rt_addr   (rt_addr),
    .i_ra_addr   (ra_addr),
    .i_rb_addr   (rb_addr),
    .i_rc_addr   (rc_addr),
    .i_ra_used   (ra_used),
    .i_rb_used   (rb_used),
    .i_rc_used   (rc_used),
    .o_struct_hz (w_struct_hz),
    .o_raw_hz    (w_raw_hz),
    .o_waw_hz    (w_waw_hz),
    .o_busy      (busy)
  );

  assign in_ready    = !ext_stall && !w_struct_hz && !w_raw_hz && !w_waw_hz;
  assign w_issue     = in_valid && in_ready;
  assign issue_valid = w_issue;
  assign issue_unit  = (w_unit == UNIT_UNDEF) ? UNIT_PERM : w_unit;

  // External stalls are someone else's problem and are not attributed here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_struct_cnt <= '0;
      r_raw_cnt    <= '0;
    end else if (in_valid && !ext_stall) begin
      if (w_struct_hz && !(&r_struct_cnt)) r_struct_cnt <= r_struct_cnt + CNT_W'(1);
      if ((w_raw_hz || w_waw_hz) && !(&r_raw_cnt)) r_raw_cnt <= r_raw_cnt + CNT_W'(1);
    end
  end

  assign struct_stall_cnt = r_struct_cnt;
  assign raw_stall_cnt    = r_raw_cnt;

endmodule
`default_nettype wire

// File: tb/tb_odd_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_odd_issue_ctrl
// Brief    : Directed self-checking bench for odd_issue_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_odd_issue_ctrl;
  import odd_pipe_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid, in_ready, reg_write, ext_stall;
  logic [1:0]       unit, issue_unit;
  logic [6:0]       rt_addr, ra_addr, rb_addr, rc_addr;
  logic             ra_used, rb_used, rc_used;
  logic             issue_valid, busy;
  logic [CNT_W-1:0] struct_stall_cnt, raw_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  odd_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .unit             (unit),
    .rt_addr          (rt_addr),
    .reg_write        (reg_write),
    .ra_addr          (ra_addr),
    .rb_addr          (rb_addr),
    .rc_addr          (rc_addr),
    .ra_used          (ra_used),
    .rb_used          (rb_used),
    .rc_used          (rc_used),
    .ext_stall        (ext_stall),
    .issue_valid      (issue_valid),
    .issue_unit       (issue_unit),
    .busy             (busy),
    .struct_stall_cnt (struct_stall_cnt),
    .raw_stall_cnt    (raw_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] u, input logic [6:0] rt, input logic wr,
                       input logic [6:0] ra, input logic rau, input logic [6:0] rb, input logic rbu,
                       input logic [6:0] rc, input logic rcu, input logic es);
    in_valid = v;  unit = u;  rt_addr = rt;  reg_write = wr;
    ra_addr = ra;  ra_used = rau;
    rb_addr = rb;  rb_used = rbu;
    rc_addr = rc;  rc_used = rcu;
    ext_stall = es;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drain();
    cyc(); idle();
    repeat (8) cyc();
  endtask

  initial begin
    idle();

    // ---- 1: reset state and first issue ----
    repeat (2) cyc();
    #1;
    check("rst_busy", busy, 0);
    check("rst_struct_cnt", struct_stall_cnt, 0);
    check("rst_raw_cnt", raw_stall_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    cyc(); reset = 1'b1;
    drive(1, UNIT_PERM, 7'd5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t1_in_ready", in_ready, 1);
    check("t1_issue_valid", issue_valid, 1);
    check("t1_busy_before", busy, 0);
    cyc(); idle(); #1;
    check("t1_busy_after", busy, 1);
    check("t1_resv4_valid", dut.u_sb.r_resv[4].valid, 1);
    check("t1_resv4_addr", dut.u_sb.r_resv[4].addr, 5);
    repeat (5) cyc(); #1;
    check("t1_drained", busy, 0);

    // ---- 2: writeback-slot collisions ----
    cyc(); drive(1, UNIT_LS, 7'd10, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_ls_ready", in_ready, 1);
    cyc(); idle();
    cyc(); drive(1, UNIT_PERM, 7'd11, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_perm_no_collide", in_ready, 1);
    drain();
    drive(1, UNIT_BR, 7'd12, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_br_ready", in_ready, 1);
    cyc(); idle();
    cyc();
    cyc(); drive(1, UNIT_PERM, 7'd13, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_perm_collide", in_ready, 0);
    check("t2_perm_collide_iv", issue_valid, 0);
    cyc(); #1;
    check("t2_perm_retry", in_ready, 1);
    check("t2_struct_cnt1", struct_stall_cnt, 1);
    drain();
    drive(1, UNIT_PERM, 7'd14, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); idle();
    cyc(); drive(1, UNIT_LS, 7'd15, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_ls_collide", in_ready, 0);
    cyc(); #1;
    check("t2_ls_slot_occupied_ok", in_ready, 1);
    check("t2_struct_cnt2", struct_stall_cnt, 2);
    check("t2_raw_cnt0", raw_stall_cnt, 0);
    drain();

    // ---- 3: RAW on rb, rc; unused source ignored ----
    drive(1, UNIT_PERM, 7'd20, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_BR, 7'd0, 0, 0, 0, 7'd20, 1, 0, 0, 0); #1;
    check("t3_raw_stall_first", in_ready, 0);
    repeat (3) cyc(); #1;
    check("t3_raw_stall_retire_cycle", in_ready, 0);
    cyc(); #1;
    check("t3_raw_issue", issue_valid, 1);
    cyc(); idle(); #1;
    check("t3_raw_cnt", raw_stall_cnt, 4);
    drain();
    drive(1, UNIT_PERM, 7'd21, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_BR, 7'd0, 0, 0, 0, 0, 0, 7'd21, 1, 0); #1;
    check("t3_rc_stall", in_ready, 0);
    cyc(); drive(1, UNIT_BR, 7'd0, 0, 7'd21, 0, 0, 0, 0, 0, 0); #1;
    check("t3_unused_src", in_ready, 1);
    cyc(); idle(); #1;
    check("t3_raw_cnt_rc", raw_stall_cnt, 5);
    drain();

    // ---- 4: WAW, reg_write=0 exempt ----
    drive(1, UNIT_BR, 7'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_PERM, 7'd3, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t4_nowrite_ok", in_ready, 1);
    cyc(); drive(1, UNIT_PERM, 7'd3, 1, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t4_waw_stall", in_ready, 0);
    repeat (5) cyc(); #1;
    check("t4_waw_stall_last", in_ready, 0);
    cyc(); #1;
    check("t4_waw_issue", in_ready, 1);
    cyc(); idle(); #1;
    check("t4_raw_cnt", raw_stall_cnt, 11);
    check("t4_struct_cnt", struct_stall_cnt, 3);
    drain();

    // ---- 5: ext_stall ----
    drive(1, UNIT_PERM, 7'd30, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_BR, 7'd0, 0, 7'd30, 1, 0, 0, 0, 0, 1); #1;
    check("t5_ext_ready", in_ready, 0);
    check("t5_ext_iv", issue_valid, 0);
    check("t5_busy", busy, 1);
    repeat (4) cyc(); #1;
    check("t5_retired", busy, 0);
    cyc(); #1;
    check("t5_raw_cnt_hold", raw_stall_cnt, 11);
    check("t5_struct_cnt_hold", struct_stall_cnt, 3);
    cyc(); drive(1, UNIT_UNDEF, 7'd0, 0, 7'd30, 1, 0, 0, 0, 0, 0); #1;
    check("t5_resume", issue_valid, 1);
    check("t5_unit_remap", issue_unit, 0);

    // ---- 6: async reset mid-flight ----
    cyc(); drive(1, UNIT_BR, 7'd40, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_BR, 7'd41, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drive(1, UNIT_BR, 7'd42, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(); idle(); #1;
    check("t6_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_busy_async", busy, 0);
    check("t6_struct_async", struct_stall_cnt, 0);
    check("t6_raw_async", raw_stall_cnt, 0);
    cyc(); reset = 1'b1;
    drive(1, UNIT_BR, 7'd0, 0, 7'd40, 1, 0, 0, 0, 0, 0); #1;
    check("t6_post_reset_issue", issue_valid, 1);

    // ---- saturation: self-dependent Br chain stalls 7 of every 8 cycles ----
    cyc(); drive(1, UNIT_BR, 7'd1, 1, 7'd1, 1, 0, 0, 0, 0, 0); #1;
    check("sat_first_issue", in_ready, 1);
    cyc(); #1;
    check("sat_then_stall", in_ready, 0);
    repeat (75000) cyc();
    #1;
    check("sat_raw_cnt", raw_stall_cnt, 16'hFFFF);
    check("sat_struct_cnt", struct_stall_cnt, 0);
    repeat (16) cyc();
    #1;
    check("sat_raw_hold", raw_stall_cnt, 16'hFFFF);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
